wr_en_checker: RTL
==================

WR_EN_CHECKER -- requirements
Module: wr_en_checker

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent write/enable channels, 1..32.
REQ-002 Parameter CNT_W, default 8: width of each per-channel violation counter, 2..16.
REQ-003 Parameter WINDOW, default 0: grace cycles after enable deasserts during which write stays legal (0 = same-cycle check only), 0..255.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 enable  input  NUM_CH  per-channel enable, sampled at posedge clk.
REQ-007 write  input  NUM_CH  per-channel write strobe, sampled at posedge clk.
REQ-008 clr  input  1  clears counters, sticky flags and first-capture; no effect on age trackers.
REQ-009 err_pulse  output  NUM_CH  registered one-cycle violation pulse per channel.
REQ-010 err_sticky  output  NUM_CH  per-channel flag, set on violation, held until clr or reset.
REQ-011 viol_cnt  output  NUM_CH*CNT_W  packed saturating violation counts; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 first_ch  output  max(1,$clog2(NUM_CH))  index of the first violating channel since reset/clr.
REQ-013 first_valid  output  1  first_ch holds a captured value.
REQ-014 any_err  output  1  OR-reduction of err_sticky, registered.

Function
REQ-015 Per channel, age = cycles since enable was last sampled high; age becomes 1 in the cycle after enable is sampled high, otherwise increments saturating at WINDOW+1.
REQ-016 At a posedge, a violation on channel i occurs when write[i]=1, enable[i]=0 and age[i] > WINDOW.
REQ-017 With WINDOW=0, a violation is exactly write & ~enable in the same cycle.
REQ-018 Latency: a violation sampled at posedge k is reflected on err_pulse, err_sticky, viol_cnt and first_ch after posedge k, so it is visible in cycle k+1; any_err is valid from the same cycle.
REQ-019 err_pulse[i] is high for exactly one cycle per violating sample; back-to-back violations hold it high continuously.
REQ-020 viol_cnt[i] increments by 1 per violation and saturates at 2^CNT_W-1 with no wrap.
REQ-021 Each channel has a two-state FSM: CLEAN, then FAULT on violation; it returns to CLEAN only on clr or reset. err_sticky[i] = (state==FAULT).
REQ-022 first_ch is captured only while first_valid=0; simultaneous violations capture the lowest channel index.
REQ-023 clr and a violation in the same cycle: the clear is applied first, then the violation is recorded (count=1, sticky=1, first_ch captured).
REQ-024 Channels are fully independent; a write on one channel is never legalised by another channel's enable.

Reset
REQ-025 While rst_n=0 at a posedge, set: err_pulse=0, err_sticky=0, viol_cnt=0, first_ch=0, first_valid=0, any_err=0, all FSMs CLEAN, all ages WINDOW+1 (expired).
REQ-026 Reset takes priority over clr and over any violation in the same cycle.
REQ-027 Reset asserted mid-window discards the grace state, so a write in the first cycle after reset with enable=0 is a violation.

Structure
REQ-028 Shared package wr_chk_pkg holds the FSM state enum (CLEAN, FAULT) and the parameter-range limit constants.
REQ-029 Per-channel logic (age tracker, FSM, counter) is the sub-module wr_chk_chan, instantiated NUM_CH times by generate; first-capture priority logic stays at top level.

Verification
REQ-030 WINDOW=0, ch0 sequence (en,wr) = (1,0),(1,1),(0,1),(1,1) -> one violation; err_pulse[0] high only in the cycle after the third sample; viol_cnt[0]=1.
REQ-031 WINDOW=2, ch1 en=1 for one cycle then 0, wr=1 on the next 3 cycles -> first two writes legal, third a violation; viol_cnt[1]=1.
REQ-032 CNT_W=2, ch2 wr=1 en=0 for 6 cycles -> viol_cnt[2] reads 1,2,3,3,3,3; err_sticky[2] stays 1.
REQ-033 Violations on ch3 and ch1 in the same cycle -> first_ch=1, first_valid=1; a later ch0 violation leaves first_ch=1.
REQ-034 clr together with a ch0 violation after viol_cnt[0]=5 -> next cycle viol_cnt[0]=1, err_sticky[0]=1, first_ch=0.
REQ-035 WINDOW=3, rst_n pulsed low one cycle after enable falls, then wr=1 en=0 -> violation flagged (grace discarded); all outputs 0 during reset.

Source files
------------

// File: rtl/wr_chk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_chk_pkg: shared types and parameter limits for wr_en_checker   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package wr_chk_pkg;

  typedef enum logic [0:0] {
    CLEAN = 1'b0,
    FAULT = 1'b1
  } chan_state_e;

  localparam int C_NUM_CH_MIN = 1;
  localparam int C_NUM_CH_MAX = 32;
  localparam int C_CNT_W_MIN  = 2;
  localparam int C_CNT_W_MAX  = 16;
  localparam int C_WINDOW_MIN = 0;
  localparam int C_WINDOW_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/wr_chk_chan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_chk_chan: one channel's age tracker, fault FSM and counter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wr_chk_chan
  import wr_chk_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             write,
  input  logic             clr,
  output logic             viol,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int               AGE_W     = $clog2(WINDOW + 2);
  localparam logic [AGE_W-1:0] C_AGE_MAX = AGE_W'(WINDOW + 1);
  localparam logic [AGE_W-1:0] C_WINDOW  = AGE_W'(WINDOW);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [AGE_W-1:0] r_age;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic             w_viol;

  // Age resets to the expired value so no grace survives a reset.
  assign w_viol = write & ~enable & (r_age > C_WINDOW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_age <= C_AGE_MAX;
    end else if (enable) begin
      r_age <= AGE_W'(1);
    end else if (r_age != C_AGE_MAX) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = CLEAN;
    end
    if (w_viol) begin
      w_state_nxt = FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear lands before a same-cycle violation, so the count restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_viol;
      if (clr) begin
        r_cnt <= w_viol ? CNT_W'(1) : '0;
      end else if (w_viol && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign viol       = w_viol;
  assign err_pulse  = r_pulse;
  assign err_sticky = (r_state == FAULT);
  assign viol_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/wr_en_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_en_checker: flags writes issued without a (recent) enable      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wr_en_checker
  import wr_chk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 0,
  localparam int FIRST_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       write,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       err_pulse,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [NUM_CH*CNT_W-1:0] viol_cnt,
  output logic [FIRST_W-1:0]      first_ch,
  output logic                    first_valid,
  output logic                    any_err
);

  logic [NUM_CH-1:0]  w_viol;
  logic               w_first_hit;
  logic [FIRST_W-1:0] w_first_idx;
  logic               w_any_nxt;
  logic [FIRST_W-1:0] r_first_ch;
  logic               r_first_valid;
  logic               r_any_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    wr_chk_chan #(
      .CNT_W  (CNT_W),
      .WINDOW (WINDOW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable[i]),
      .write      (write[i]),
      .clr        (clr),
      .viol       (w_viol[i]),
      .err_pulse  (err_pulse[i]),
      .err_sticky (err_sticky[i]),
      .viol_cnt   (viol_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Descending scan so the lowest violating index wins.
  always_comb begin
    w_first_hit = 1'b0;
    w_first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_viol[i]) begin
        w_first_hit = 1'b1;
        w_first_idx = FIRST_W'(i);
      end
    end
  end

  // Mirrors the channels' next sticky state so any_err lines up with err_sticky.
  assign w_any_nxt = |((err_sticky & ~{NUM_CH{clr}}) | w_viol);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first_ch    <= '0;
      r_first_valid <= 1'b0;
      r_any_err     <= 1'b0;
    end else begin
      r_any_err <= w_any_nxt;
      if (clr) begin
        r_first_ch    <= w_first_idx;
        r_first_valid <= w_first_hit;
      end else if (!r_first_valid && w_first_hit) begin
        r_first_ch    <= w_first_idx;
        r_first_valid <= 1'b1;
      end
    end
  end

  assign first_ch    = r_first_ch;
  assign first_valid = r_first_valid;
  assign any_err     = r_any_err;

endmodule
`default_nettype wire
